// File: rtl/idu2phy_dispatch_queue_pkg.sv
// Shared types and widths for the rename-to-regfile dispatch queue.
// Per-lane payload bundle and packed control word.
package idu2phy_dispatch_queue_pkg;

  localparam int INST_ADDR_WIDTH = 32;
  localparam int PHYSICAL_REG_NUM_WIDTH = 7;
  localparam int ARCH_REG_NUM_WIDTH = 5;
  localparam int GENERATED_IMMEDIATE_WIDTH = 32;
  localparam int ROB_SIZE_WIDTH = 5;
  localparam int CONTROL_WIDTH = 16;

  typedef struct packed {
    logic [3:0] fu_sel;
    logic [4:0] alu_op;
    logic       mem_rd;
    logic       mem_wr;
    logic       reg_wr;
    logic       imm_sel;
    logic       branch;
    logic       jump;
    logic       csr;
  } control_t;

  typedef struct packed {
    control_t                                control;
    logic [INST_ADDR_WIDTH-1:0]              pc;
    logic [PHYSICAL_REG_NUM_WIDTH-1:0]       rs1;
    logic [PHYSICAL_REG_NUM_WIDTH-1:0]       rs2;
    logic [PHYSICAL_REG_NUM_WIDTH-1:0]       rd;
    logic [GENERATED_IMMEDIATE_WIDTH-1:0]    imm;
    logic [ROB_SIZE_WIDTH-1:0]               tag;
    logic [ARCH_REG_NUM_WIDTH-1:0]           arch_rd;
  } dispatch_lane_t;

  localparam int DISPATCH_LANE_BITS = $bits(dispatch_lane_t);

endpackage

// File: rtl/idu2phy_dispatch_queue_ptr_ctrl.sv
// Head/tail/count bookkeeping for the dispatch queue ring.
// Reset beats flush; flush drops any push or pop in its cycle.
import idu2phy_dispatch_queue_pkg::*;

module dq_ptr_ctrl #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push_req,
  input  logic             pop_req,
  output logic             push,
  output logic             pop,
  output logic [PTR_W-1:0] head,
  output logic [PTR_W-1:0] tail,
  output logic [CNT_W-1:0] count,
  output logic             in_ready,
  output logic             out_valid
);

  assign in_ready  = (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push = push_req && in_ready && !flush;
  assign pop  = pop_req && out_valid && !flush;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push)
        tail <= tail + PTR_W'(1);
      if (pop)
        head <= head + PTR_W'(1);
      unique case (1'b1)
        push && !pop: count <= count + CNT_W'(1);
        pop && !push: count <= count - CNT_W'(1);
        default:      count <= count;
      endcase
    end
  end

endmodule

// File: rtl/idu2phy_dispatch_queue.sv
// Multi-lane bundle FIFO between rename and physical regfile read.
// Storage lives here; pointer/count control is in dq_ptr_ctrl.
import idu2phy_dispatch_queue_pkg::*;

module idu2phy_dispatch_queue #(
  parameter int LANES       = 2,
  parameter int DEPTH       = 4,
  parameter int CTRL_W      = CONTROL_WIDTH,
  parameter int INST_ADDR_W = INST_ADDR_WIDTH,
  parameter int PHY_REG_W   = PHYSICAL_REG_NUM_WIDTH,
  parameter int ARCH_REG_W  = ARCH_REG_NUM_WIDTH,
  parameter int IMM_W       = GENERATED_IMMEDIATE_WIDTH,
  parameter int TAG_W       = ROB_SIZE_WIDTH,
  parameter int CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [LANES-1:0]             in_lane_valid,
  output logic                         in_ready,
  input  logic [LANES*CTRL_W-1:0]      in_control,
  input  logic [LANES*INST_ADDR_W-1:0] in_pc,
  input  logic [LANES*PHY_REG_W-1:0]   in_rs1,
  input  logic [LANES*PHY_REG_W-1:0]   in_rs2,
  input  logic [LANES*PHY_REG_W-1:0]   in_rd,
  input  logic [LANES*IMM_W-1:0]       in_imm,
  input  logic [LANES*TAG_W-1:0]       in_tag,
  input  logic [LANES*ARCH_REG_W-1:0]  in_arch_rd,
  output logic                         out_valid,
  output logic [LANES-1:0]             out_lane_valid,
  input  logic                         out_ready,
  output logic [LANES*CTRL_W-1:0]      out_control,
  output logic [LANES*INST_ADDR_W-1:0] out_pc,
  output logic [LANES*PHY_REG_W-1:0]   out_rs1,
  output logic [LANES*PHY_REG_W-1:0]   out_rs2,
  output logic [LANES*PHY_REG_W-1:0]   out_rd,
  output logic [LANES*IMM_W-1:0]       out_imm,
  output logic [LANES*TAG_W-1:0]       out_tag,
  output logic [LANES*ARCH_REG_W-1:0]  out_arch_rd,
  output logic [CNT_W-1:0]             occupancy
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int LANE_W = CTRL_W + INST_ADDR_W
                        + 3 * PHY_REG_W + IMM_W
                        + TAG_W + ARCH_REG_W;

  logic [LANE_W-1:0] mem [DEPTH][LANES];
  logic [LANES-1:0]  mask_q [DEPTH];

  logic             push;
  logic             pop;
  logic             push_req;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  assign push_req = |in_lane_valid;

  dq_ptr_ctrl #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .CNT_W (CNT_W)
  ) u_ptr (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push_req  (push_req),
    .pop_req   (out_ready),
    .push      (push),
    .pop       (pop),
    .head      (head),
    .tail      (tail),
    .count     (count),
    .in_ready  (in_ready),
    .out_valid (out_valid)
  );

  // Payload is intentionally left unreset; only masks gate visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int l = 0; l < LANES; l++) begin
        mem[tail][l] <= {
          in_control[l*CTRL_W +: CTRL_W],
          in_pc[l*INST_ADDR_W +: INST_ADDR_W],
          in_rs1[l*PHY_REG_W +: PHY_REG_W],
          in_rs2[l*PHY_REG_W +: PHY_REG_W],
          in_rd[l*PHY_REG_W +: PHY_REG_W],
          in_imm[l*IMM_W +: IMM_W],
          in_tag[l*TAG_W +: TAG_W],
          in_arch_rd[l*ARCH_REG_W +: ARCH_REG_W]
        };
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int d = 0; d < DEPTH; d++)
        mask_q[d] <= '0;
    end else if (push) begin
      mask_q[tail] <= in_lane_valid;
    end
  end

  always_comb begin
    out_control = '0;
    out_pc      = '0;
    out_rs1     = '0;
    out_rs2     = '0;
    out_rd      = '0;
    out_imm     = '0;
    out_tag     = '0;
    out_arch_rd = '0;
    for (int l = 0; l < LANES; l++) begin
      {
        out_control[l*CTRL_W +: CTRL_W],
        out_pc[l*INST_ADDR_W +: INST_ADDR_W],
        out_rs1[l*PHY_REG_W +: PHY_REG_W],
        out_rs2[l*PHY_REG_W +: PHY_REG_W],
        out_rd[l*PHY_REG_W +: PHY_REG_W],
        out_imm[l*IMM_W +: IMM_W],
        out_tag[l*TAG_W +: TAG_W],
        out_arch_rd[l*ARCH_REG_W +: ARCH_REG_W]
      } = mem[head][l];
    end
  end

  assign out_lane_valid = mask_q[head] & {LANES{out_valid}};
  assign occupancy      = count;

endmodule

// File: tb/tb_idu2phy_dispatch_queue.sv
// Scoreboard bench for idu2phy_dispatch_queue (LANES=2, DEPTH=4).
// Stimulus enqueues expected bundles; a negedge monitor checks pops.
module tb_idu2phy_dispatch_queue;

  logic        clk = 0;
  logic        reset;
  logic        flush;
  logic [1:0]  in_lane_valid;
  logic        in_ready;
  logic [31:0] in_control;
  logic [63:0] in_pc;
  logic [13:0] in_rs1, in_rs2, in_rd;
  logic [63:0] in_imm;
  logic [9:0]  in_tag, in_arch_rd;
  logic        out_valid;
  logic [1:0]  out_lane_valid;
  logic        out_ready;
  logic [31:0] out_control;
  logic [63:0] out_pc;
  logic [13:0] out_rs1, out_rs2, out_rd;
  logic [63:0] out_imm;
  logic [9:0]  out_tag, out_arch_rd;
  logic [2:0]  occupancy;

  typedef struct {
    logic [1:0]  m;
    logic [31:0] ctrl;
    logic [63:0] pc;
    logic [13:0] rs1, rs2, rd;
    logic [63:0] imm;
    logic [9:0]  tag, arch;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  idu2phy_dispatch_queue dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_lane_valid(in_lane_valid), .in_ready(in_ready),
    .in_control(in_control), .in_pc(in_pc),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_imm(in_imm), .in_tag(in_tag),
    .in_arch_rd(in_arch_rd),
    .out_valid(out_valid), .out_lane_valid(out_lane_valid),
    .out_ready(out_ready),
    .out_control(out_control), .out_pc(out_pc),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_imm(out_imm), .out_tag(out_tag),
    .out_arch_rd(out_arch_rd),
    .occupancy(occupancy)
  );

  task automatic chk(input string n,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_lane_valid = 2'b00;
  endtask

  // Lane 0 sits in the low bits; other fields derive from tag/pc.
  task automatic send(input logic [1:0] m,
                      input logic [4:0] t1, input logic [4:0] t0,
                      input logic [31:0] pc0,
                      input logic rdy, input logic enq);
    exp_t e;
    e.m    = m;
    e.tag  = {t1, t0};
    e.pc   = {pc0 + 32'h4, pc0};
    e.ctrl = {pc0[15:0] ^ 16'h1234, pc0[15:0] ^ 16'h5a5a};
    e.rs1  = {2'b00, t1, 2'b00, t0};
    e.rs2  = {2'b11, t1, 2'b11, t0};
    e.rd   = {2'b10, t1, 2'b01, t0};
    e.imm  = ~e.pc;
    e.arch = {t1 ^ 5'h15, t0 ^ 5'h0a};
    in_lane_valid = m;
    in_tag     = e.tag;
    in_pc      = e.pc;
    in_control = e.ctrl;
    in_rs1     = e.rs1;
    in_rs2     = e.rs2;
    in_rd      = e.rd;
    in_imm     = e.imm;
    in_arch_rd = e.arch;
    chk("in_ready", 64'(in_ready), 64'(rdy));
    if (enq && m != 2'b00)
      sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!reset && !flush && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_pop", 64'(out_tag), 64'h3ff_ffff);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_lane_valid", 64'(out_lane_valid), 64'(e.m));
        chk("out_tag", 64'(out_tag), 64'(e.tag));
        chk("out_pc", out_pc, e.pc);
        chk("out_control", 64'(out_control), 64'(e.ctrl));
        chk("out_rs1", 64'(out_rs1), 64'(e.rs1));
        chk("out_rs2", 64'(out_rs2), 64'(e.rs2));
        chk("out_rd", 64'(out_rd), 64'(e.rd));
        chk("out_imm", out_imm, e.imm);
        chk("out_arch_rd", 64'(out_arch_rd), 64'(e.arch));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1;
    flush = 0;
    out_ready = 0;
    in_lane_valid = 0;
    in_control = 0; in_pc = 0; in_rs1 = 0; in_rs2 = 0;
    in_rd = 0; in_imm = 0; in_tag = 0; in_arch_rd = 0;
    step();
    step();
    reset = 0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_lane_valid", 64'(out_lane_valid), 64'd0);
    chk("rst_occ", 64'(occupancy), 64'd0);

    // single push: lane1 tag 3 / pc 104, lane0 tag 4 / pc 100
    send(2'b11, 5'd3, 5'd4, 32'h100, 1, 1);
    step();
    idle();
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_occ", 64'(occupancy), 64'd1);
    chk("single_tag", 64'(out_tag), 64'h064);
    chk("single_pc", out_pc, 64'h0000_0104_0000_0100);
    out_ready = 1;
    step();
    out_ready = 0;
    chk("single_drain_occ", 64'(occupancy), 64'd0);

    // fill to full, fifth push refused
    for (int k = 0; k < 4; k++) begin
      send(2'b11, 5'(2*k+1), 5'(2*k), 32'h1000 + 32'(k*8), 1, 1);
      step();
      chk("fill_occ", 64'(occupancy), 64'(k+1));
    end
    send(2'b11, 5'd9, 5'd8, 32'h1100, 0, 0);
    step();
    idle();
    chk("full_occ", 64'(occupancy), 64'd4);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("drain_occ", 64'(occupancy), 64'(3-k));
      chk("drain_in_ready", 64'(in_ready), 64'd1);
    end
    out_ready = 0;

    // steady push+pop at occupancy 2, pointers wrap
    send(2'b11, 5'd11, 5'd10, 32'h2000, 1, 1);
    step();
    send(2'b11, 5'd13, 5'd12, 32'h2010, 1, 1);
    step();
    out_ready = 1;
    for (int k = 0; k < 10; k++) begin
      send(2'b11, 5'(14+2*k+1), 5'(14+2*k),
           32'h3000 + 32'(k*16), 1, 1);
      step();
      chk("steady_occ", 64'(occupancy), 64'd2);
    end
    idle();
    step();
    step();
    out_ready = 0;
    chk("steady_drain_occ", 64'(occupancy), 64'd0);

    // partial mask then all-invalid bundle
    send(2'b01, 5'd21, 5'd20, 32'h4000, 1, 1);
    step();
    send(2'b00, 5'd23, 5'd22, 32'h4010, 1, 1);
    step();
    idle();
    chk("partial_occ", 64'(occupancy), 64'd1);
    chk("partial_mask", 64'(out_lane_valid), 64'd1);
    out_ready = 1;
    step();
    out_ready = 0;
    chk("partial_drain_occ", 64'(occupancy), 64'd0);

    // flush with 3 entries and concurrent push/pop
    for (int k = 0; k < 3; k++) begin
      send(2'b11, 5'(2*k+1), 5'(2*k), 32'h5000 + 32'(k*8), 1, 1);
      step();
    end
    chk("preflush_occ", 64'(occupancy), 64'd3);
    flush = 1;
    out_ready = 1;
    send(2'b11, 5'd31, 5'd30, 32'h5100, 1, 0);
    step();
    flush = 0;
    out_ready = 0;
    idle();
    sb.delete();
    chk("flush_occ", 64'(occupancy), 64'd0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_lane_valid", 64'(out_lane_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    send(2'b10, 5'd17, 5'd16, 32'h6000, 1, 1);
    step();
    idle();
    chk("postflush_valid", 64'(out_valid), 64'd1);
    chk("postflush_mask", 64'(out_lane_valid), 64'd2);
    out_ready = 1;
    step();
    out_ready = 0;

    // reset mid-stream
    send(2'b11, 5'd5, 5'd6, 32'h7000, 1, 1);
    step();
    send(2'b11, 5'd7, 5'd8, 32'h7008, 1, 1);
    step();
    idle();
    reset = 1;
    step();
    reset = 0;
    sb.delete();
    chk("midrst_occ", 64'(occupancy), 64'd0);
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_mask", 64'(out_lane_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
